// File: rtl/irr_edge_level_if.sv
// rtl/irr_edge_level_if.sv - request/mask/clear and resolver-view bundle for the interrupt request register
interface irr_edge_level_if #(
  parameter int NUM_IRQ = 8
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] ir;
  logic [NUM_IRQ-1:0] imr;
  logic               ltim;
  logic               freeze;
  logic               clr_valid;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] irr_masked;
  logic               int_req;
  logic [ID_W-1:0]    irq_id;

  modport master (
    output ir, imr, ltim, freeze, clr_valid, clr_mask,
    input  irr, irr_masked, int_req, irq_id
  );

  modport slave (
    input  ir, imr, ltim, freeze, clr_valid, clr_mask,
    output irr, irr_masked, int_req, irq_id
  );
endinterface

// File: rtl/irr_edge_level.sv
// rtl/irr_edge_level.sv - PIC interrupt request register, edge/level capture with freeze and clear
// Optional input synchroniser chain enabled by defining IRR_SYNC_EN.
module irr_edge_level #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  irr_edge_level_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_IRQ);

  if (NUM_IRQ < 2 || NUM_IRQ > 32 || SYNC_STAGES < 2) begin : g_bad_param
    $error("irr_edge_level: illegal parameter value");
  end

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] masked;
  logic [ID_W-1:0]    irq_id;

`ifdef IRR_SYNC_EN
  // Chain resets high so a line held high through reset never looks like a fresh edge.
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.ir;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = bus.ir;
`endif

  assign rise = s & ~prev_q;

  always_comb begin
    prev_d = bus.freeze ? prev_q : s;
    irr_d  = irr_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (bus.clr_valid && bus.clr_mask[i]) begin
        irr_d[i] = 1'b0;
      end else if (bus.freeze) begin
        irr_d[i] = irr_q[i];
      end else if (bus.ltim) begin
        irr_d[i] = s[i];
      end else begin
        // Edge mode: a request that drops before acknowledge withdraws itself.
        irr_d[i] = (irr_q[i] | rise[i]) & s[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '1;
      irr_q  <= '0;
    end else begin
      prev_q <= prev_d;
      irr_q  <= irr_d;
    end
  end

  assign masked = irr_q & ~bus.imr;

  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        irq_id = ID_W'(i);
      end
    end
  end

  assign bus.irr        = irr_q;
  assign bus.irr_masked = masked;
  assign bus.int_req    = |masked;
  assign bus.irq_id     = irq_id;
endmodule

// File: tb/tb_irr_edge_level.sv
// tb/tb_irr_edge_level.sv - directed self-checking bench for irr_edge_level (default build)
module tb_irr_edge_level;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  irr_edge_level_if #(.NUM_IRQ(8)) bus ();

  irr_edge_level #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.ir = 8'h00; bus.imr = 8'h00; bus.ltim = 1'b0; bus.freeze = 1'b0;
    bus.clr_valid = 1'b0; bus.clr_mask = 8'h00;
    cyc(); cyc();
    chk("rst_irr", 32'(bus.irr), 32'h00);
    chk("rst_int_req", 32'(bus.int_req), 32'h0);
    chk("rst_irq_id", 32'(bus.irq_id), 32'h0);
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("idle_irr", 32'(bus.irr), 32'h00);

    // edge capture
    bus.ir = 8'h08;
    #1 chk("edge_pre", 32'(bus.irr), 32'h00);
    cyc();
    chk("edge_irr", 32'(bus.irr), 32'h08);
    chk("edge_int_req", 32'(bus.int_req), 32'h1);
    chk("edge_irq_id", 32'(bus.irq_id), 32'h3);
    bus.ir = 8'h00;
    cyc();
    chk("edge_drop", 32'(bus.irr), 32'h00);

    // withdraw after 3 high cycles
    bus.ir = 8'h04;
    cyc(); chk("wd_1", 32'(bus.irr), 32'h04);
    cyc(); chk("wd_2", 32'(bus.irr), 32'h04);
    cyc(); chk("wd_3", 32'(bus.irr), 32'h04);
    bus.ir = 8'h00;
    cyc(); chk("wd_gone", 32'(bus.irr), 32'h00);

    // clear under level mode
    bus.ltim = 1'b1; bus.ir = 8'h20;
    cyc(); chk("lvl_set", 32'(bus.irr), 32'h20);
    bus.clr_valid = 1'b1; bus.clr_mask = 8'h20;
    cyc(); chk("lvl_clr", 32'(bus.irr), 32'h00);
    bus.clr_valid = 1'b0;
    cyc(); chk("lvl_reset", 32'(bus.irr), 32'h20);

    // clear under edge mode
    bus.ltim = 1'b0;
    cyc(); chk("edg_hold", 32'(bus.irr), 32'h20);
    bus.clr_valid = 1'b1;
    cyc(); chk("edg_clr", 32'(bus.irr), 32'h00);
    bus.clr_valid = 1'b0; bus.clr_mask = 8'h00;
    cyc(); chk("edg_stay1", 32'(bus.irr), 32'h00);
    cyc(); chk("edg_stay2", 32'(bus.irr), 32'h00);
    bus.ir = 8'h00;
    cyc(); chk("edg_low", 32'(bus.irr), 32'h00);
    bus.ir = 8'h20;
    cyc(); chk("edg_reset", 32'(bus.irr), 32'h20);
    bus.ir = 8'h00;
    cyc(); chk("edg_clean", 32'(bus.irr), 32'h00);

    // mask and priority
    bus.ir = 8'h42;
    cyc(); chk("mp_irr", 32'(bus.irr), 32'h42);
    bus.imr = 8'h02;
    #1;
    chk("mp_masked", 32'(bus.irr_masked), 32'h40);
    chk("mp_id6", 32'(bus.irq_id), 32'h6);
    chk("mp_irr_unmasked", 32'(bus.irr), 32'h42);
    bus.imr = 8'h00;
    #1 chk("mp_id1", 32'(bus.irq_id), 32'h1);
    bus.imr = 8'h42;
    #1;
    chk("mp_all_int_req", 32'(bus.int_req), 32'h0);
    chk("mp_all_id", 32'(bus.irq_id), 32'h0);
    bus.imr = 8'h00;

    // freeze with clear
    bus.ir = 8'h43;
    cyc(); chk("fz_pre", 32'(bus.irr), 32'h43);
    bus.freeze = 1'b1; bus.ir = 8'h53;
    cyc(); chk("fz_hold1", 32'(bus.irr), 32'h43);
    cyc(); chk("fz_hold2", 32'(bus.irr), 32'h43);
    bus.clr_valid = 1'b1; bus.clr_mask = 8'h01;
    cyc(); chk("fz_clr", 32'(bus.irr), 32'h42);
    bus.clr_valid = 1'b0; bus.clr_mask = 8'h00; bus.freeze = 1'b0;
    cyc(); chk("fz_release", 32'(bus.irr), 32'h52);

    // multi-hot clear
    bus.clr_valid = 1'b1; bus.clr_mask = 8'h50;
    cyc(); chk("multi_clr", 32'(bus.irr), 32'h02);
    bus.clr_valid = 1'b0; bus.clr_mask = 8'hFF;
    cyc(); chk("clr_ignored", 32'(bus.irr), 32'h02);
    bus.clr_mask = 8'h00;

    // reset with lines held high
    bus.ir = 8'hFF;
    reset = 1'b1;
    #1 chk("async_rst", 32'(bus.irr), 32'h00);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); chk("rh_1", 32'(bus.irr), 32'h00);
    cyc(); chk("rh_2", 32'(bus.irr), 32'h00);
    bus.ir = 8'h7F;
    cyc(); chk("rh_low", 32'(bus.irr), 32'h00);
    bus.ir = 8'hFF;
    cyc();
    chk("rh_rise", 32'(bus.irr), 32'h80);
    chk("rh_id", 32'(bus.irq_id), 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
